// File: rtl/id_ex_pipe_if.sv
// id_ex_pipe_if: ID-side inputs, control inputs and EX-side outputs of the ID/EX register.
// The master modport is the ID/control side; the slave modport is the pipeline register.
interface id_ex_pipe_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic            id_valid;
    logic [6:0]      id_op;
    logic [4:0]      id_rd;
    logic [4:0]      id_src1;
    logic [4:0]      id_src2;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_pc;
    logic            id_regWrite;
    logic            id_memRead;
    logic            id_memWrite;
    logic            mem_stall;
    logic            flush;
    logic            wb_regWrite;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            ex_valid;
    logic [6:0]      ex_op;
    logic [4:0]      ex_rd;
    logic [4:0]      ex_src1;
    logic [4:0]      ex_src2;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_pc;
    logic            ex_regWrite;
    logic            ex_memRead;
    logic            ex_memWrite;
    logic            stall_id;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output id_valid, id_op, id_rd, id_src1, id_src2, id_rs1_data, id_rs2_data, id_imm, id_pc,
               id_regWrite, id_memRead, id_memWrite, mem_stall, flush, wb_regWrite, wb_rd, wb_data,
        input  ex_valid, ex_op, ex_rd, ex_src1, ex_src2, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc,
               ex_regWrite, ex_memRead, ex_memWrite, stall_id, bubble_cnt
    );
    modport slave (
        input  id_valid, id_op, id_rd, id_src1, id_src2, id_rs1_data, id_rs2_data, id_imm, id_pc,
               id_regWrite, id_memRead, id_memWrite, mem_stall, flush, wb_regWrite, wb_rd, wb_data,
        output ex_valid, ex_op, ex_rd, ex_src1, ex_src2, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc,
               ex_regWrite, ex_memRead, ex_memWrite, stall_id, bubble_cnt
    );
endinterface

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX register with load-use bubble insertion, memory-stall hold and branch flush.
// Optional ID_WB_BYPASS_EN: same-cycle WB->ID operand bypass when the register file is not write-first.
module id_ex_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input logic         clk,
    input logic         rst,
    id_ex_pipe_if.slave bus_io
);
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] I_TYPE  = 7'b0010011;
    localparam logic [6:0] OP_AUPC = 7'b0010111;
    localparam logic [6:0] U_TYPE  = 7'b0110111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] J_TYPE  = 7'b1101111;

    typedef struct packed {
        logic            valid;
        logic [6:0]      op;
        logic [4:0]      rd;
        logic [4:0]      src1;
        logic [4:0]      src2;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } ex_t;

    ex_t              ex_q, ex_d, cap;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             use1, use2, load_use, byp1, byp2;

    assign use1 = !(bus_io.id_op inside {OP_AUPC, U_TYPE, J_TYPE});
    assign use2 = !(bus_io.id_op inside {I_TYPE, U_TYPE, J_TYPE, OP_LW, OP_JALR, OP_AUPC});
    assign load_use = ex_q.valid && ex_q.mem_read && ex_q.rd != 5'd0 && bus_io.id_valid &&
                      ((use1 && ex_q.rd == bus_io.id_src1) || (use2 && ex_q.rd == bus_io.id_src2));
    assign bus_io.stall_id = bus_io.mem_stall || (load_use && !bus_io.flush);

`ifdef ID_WB_BYPASS_EN
    assign byp1 = bus_io.wb_regWrite && bus_io.wb_rd != 5'd0 && bus_io.wb_rd == bus_io.id_src1;
    assign byp2 = bus_io.wb_regWrite && bus_io.wb_rd != 5'd0 && bus_io.wb_rd == bus_io.id_src2;
`else
    logic unused_wb;
    assign unused_wb = ^{bus_io.wb_regWrite, bus_io.wb_rd, bus_io.wb_data};
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign cap = '{
        valid:     bus_io.id_valid,
        op:        bus_io.id_op,
        rd:        bus_io.id_rd,
        src1:      bus_io.id_src1,
        src2:      bus_io.id_src2,
        rs1:       byp1 ? bus_io.wb_data : bus_io.id_rs1_data,
        rs2:       byp2 ? bus_io.wb_data : bus_io.id_rs2_data,
        imm:       bus_io.id_imm,
        pc:        bus_io.id_pc,
        reg_write: bus_io.id_regWrite && bus_io.id_valid,
        mem_read:  bus_io.id_memRead && bus_io.id_valid,
        mem_write: bus_io.id_memWrite && bus_io.id_valid
    };

    // A flush seen during a stall is remembered so the killed instruction still gets squashed.
    always_comb begin
        ex_d   = ex_q;
        pend_d = pend_q;
        cnt_d  = cnt_q;
        if (bus_io.mem_stall) begin
            pend_d = pend_q || bus_io.flush;
        end else if (bus_io.flush || pend_q) begin
            ex_d   = '0;
            pend_d = 1'b0;
        end else if (load_use) begin
            ex_d  = '0;
            cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
        end else begin
            ex_d = cap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q   <= '0;
            pend_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            ex_q   <= ex_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus_io.ex_valid    = ex_q.valid;
    assign bus_io.ex_op       = ex_q.op;
    assign bus_io.ex_rd       = ex_q.rd;
    assign bus_io.ex_src1     = ex_q.src1;
    assign bus_io.ex_src2     = ex_q.src2;
    assign bus_io.ex_rs1_data = ex_q.rs1;
    assign bus_io.ex_rs2_data = ex_q.rs2;
    assign bus_io.ex_imm      = ex_q.imm;
    assign bus_io.ex_pc       = ex_q.pc;
    assign bus_io.ex_regWrite = ex_q.reg_write;
    assign bus_io.ex_memRead  = ex_q.mem_read;
    assign bus_io.ex_memWrite = ex_q.mem_write;
    assign bus_io.bubble_cnt  = cnt_q;
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed scenarios for the ID/EX register (reset, pass-through, load-use,
// unused sources, flush priority, stall with pending flush, WB bypass).
module tb_id_ex_pipe;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] R_TYPE = 7'b0110011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    id_ex_pipe_if #(.XLEN(32), .CNT_W(16)) bus ();
    id_ex_pipe #(.XLEN(32), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus_io(bus.slave));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd, s1, s2,
                         input logic [31:0] r1, r2, imm, pc, input logic rw, mr, mw);
        bus.id_valid = v; bus.id_op = op; bus.id_rd = rd; bus.id_src1 = s1; bus.id_src2 = s2;
        bus.id_rs1_data = r1; bus.id_rs2_data = r2; bus.id_imm = imm; bus.id_pc = pc;
        bus.id_regWrite = rw; bus.id_memRead = mr; bus.id_memWrite = mw;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.ex_valid !== 1'b0 || bus.bubble_cnt !== 16'd0) begin errors++; $display("FAIL reset_init: ex_valid=%b cnt=%0d, want 0/0", bus.ex_valid, bus.bubble_cnt); end
        tick(); rst = 1'b0;
        drive(1, R_TYPE, 5'd6, 5'd1, 5'd2, 32'h11, 32'h22, 32'h33, 32'h100, 1, 0, 0);
        tick();
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6) begin errors++; $display("FAIL reset_load: ex_valid=%b ex_rd=%0d, want 1/6", bus.ex_valid, bus.ex_rd); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({bus.ex_valid, bus.ex_op, bus.ex_rd, bus.ex_rs1_data, bus.ex_pc, bus.ex_regWrite} !== '0 || bus.bubble_cnt !== 16'd0) begin errors++; $display("FAIL reset_async: ex_valid=%b op=%h rd=%0d rs1=%h pc=%h rw=%b cnt=%0d, want all 0", bus.ex_valid, bus.ex_op, bus.ex_rd, bus.ex_rs1_data, bus.ex_pc, bus.ex_regWrite, bus.bubble_cnt); end
        tick(); rst = 1'b0;
        bus.mem_stall = 1'b1; bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        bus.mem_stall = 1'b0;
        tick();
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6) begin errors++; $display("FAIL reset_clears_pend: ex_valid=%b ex_rd=%0d, want 1/6", bus.ex_valid, bus.ex_rd); end
    endtask

    task automatic test_passthrough();
        drive(1, R_TYPE, 5'd12, 5'd3, 5'd4, 32'hA, 32'hB, 32'hC0FFEE, 32'h2000, 0, 0, 1);
        tick();
        checks++; if (bus.ex_imm !== 32'hC0FFEE || bus.ex_pc !== 32'h2000 || bus.ex_memWrite !== 1'b1 || bus.ex_src2 !== 5'd4 || bus.ex_op !== R_TYPE) begin errors++; $display("FAIL pass_fields: imm=%h pc=%h mw=%b src2=%0d op=%h, want c0ffee/2000/1/4/33", bus.ex_imm, bus.ex_pc, bus.ex_memWrite, bus.ex_src2, bus.ex_op); end
        drive(0, OP_LW, 5'd7, 5'd1, 5'd2, 32'h1, 32'h2, 32'h3, 32'h4, 1, 1, 1);
        tick();
        checks++; if (bus.ex_valid !== 1'b0 || bus.ex_regWrite !== 1'b0 || bus.ex_memRead !== 1'b0 || bus.ex_memWrite !== 1'b0 || bus.ex_rd !== 5'd7) begin errors++; $display("FAIL pass_gating: v=%b rw=%b mr=%b mw=%b rd=%0d, want 0/0/0/0/7", bus.ex_valid, bus.ex_regWrite, bus.ex_memRead, bus.ex_memWrite, bus.ex_rd); end
    endtask

    task automatic test_load_use();
        drive(1, OP_LW, 5'd5, 5'd1, 5'd0, 32'h0, 32'h0, 32'h8, 32'h40, 1, 1, 0);
        tick();
        drive(1, R_TYPE, 5'd6, 5'd5, 5'd7, 32'h0, 32'h0, 32'h0, 32'h44, 1, 0, 0);
        #1;
        checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL lu_stall_src1: stall_id=%b, want 1", bus.stall_id); end
        tick();
        checks++; if (bus.ex_valid !== 1'b0 || bus.ex_rd !== 5'd0 || bus.ex_regWrite !== 1'b0 || bus.bubble_cnt !== 16'd1 || bus.stall_id !== 1'b0) begin errors++; $display("FAIL lu_bubble: v=%b rd=%0d rw=%b cnt=%0d stall=%b, want 0/0/0/1/0", bus.ex_valid, bus.ex_rd, bus.ex_regWrite, bus.bubble_cnt, bus.stall_id); end
        tick();
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6 || bus.ex_src1 !== 5'd5 || bus.ex_pc !== 32'h44) begin errors++; $display("FAIL lu_enter: v=%b rd=%0d src1=%0d pc=%h, want 1/6/5/44", bus.ex_valid, bus.ex_rd, bus.ex_src1, bus.ex_pc); end
        drive(1, OP_LW, 5'd5, 5'd1, 5'd0, 32'h0, 32'h0, 32'h8, 32'h48, 1, 1, 0);
        tick();
        drive(1, R_TYPE, 5'd6, 5'd7, 5'd5, 32'h0, 32'h0, 32'h0, 32'h4C, 1, 0, 0);
        #1;
        checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL lu_stall_src2: stall_id=%b, want 1", bus.stall_id); end
        tick();
        checks++; if (bus.ex_valid !== 1'b0 || bus.bubble_cnt !== 16'd2) begin errors++; $display("FAIL lu_bubble2: v=%b cnt=%0d, want 0/2", bus.ex_valid, bus.bubble_cnt); end
        tick();
        checks++; if (bus.ex_rd !== 5'd6 || bus.ex_valid !== 1'b1) begin errors++; $display("FAIL lu_enter2: rd=%0d v=%b, want 6/1", bus.ex_rd, bus.ex_valid); end
    endtask

    task automatic test_unused_src();
        drive(1, OP_LW, 5'd5, 5'd1, 5'd0, 32'h0, 32'h0, 32'h0, 32'h50, 1, 1, 0);
        tick();
        drive(1, I_TYPE, 5'd6, 5'd0, 5'd5, 32'h0, 32'h0, 32'h5, 32'h54, 1, 0, 0);
        #1;
        checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL unused_src2_stall: stall_id=%b, want 0", bus.stall_id); end
        tick();
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6 || bus.bubble_cnt !== 16'd2) begin errors++; $display("FAIL unused_src2_enter: v=%b rd=%0d cnt=%0d, want 1/6/2", bus.ex_valid, bus.ex_rd, bus.bubble_cnt); end
        drive(1, OP_LW, 5'd0, 5'd1, 5'd0, 32'h0, 32'h0, 32'h0, 32'h58, 1, 1, 0);
        tick();
        drive(1, R_TYPE, 5'd6, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h5C, 1, 0, 0);
        #1;
        checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL lw_x0_stall: stall_id=%b, want 0", bus.stall_id); end
        tick();
    endtask

    task automatic test_flush_priority();
        drive(1, OP_LW, 5'd5, 5'd1, 5'd0, 32'h0, 32'h0, 32'h0, 32'h60, 1, 1, 0);
        tick();
        drive(1, R_TYPE, 5'd6, 5'd5, 5'd7, 32'h0, 32'h0, 32'h0, 32'h64, 1, 0, 0);
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL flush_stall: stall_id=%b, want 0", bus.stall_id); end
        tick();
        bus.flush = 1'b0;
        checks++; if (bus.ex_valid !== 1'b0 || bus.ex_regWrite !== 1'b0 || bus.bubble_cnt !== 16'd2) begin errors++; $display("FAIL flush_bubble: v=%b rw=%b cnt=%0d, want 0/0/2", bus.ex_valid, bus.ex_regWrite, bus.bubble_cnt); end
    endtask

    task automatic test_mem_stall_flush();
        drive(1, I_TYPE, 5'd9, 5'd1, 5'd0, 32'h0, 32'h0, 32'h9, 32'h70, 1, 0, 0);
        tick();
        checks++; if (bus.ex_rd !== 5'd9) begin errors++; $display("FAIL stall_setup: ex_rd=%0d, want 9", bus.ex_rd); end
        drive(1, I_TYPE, 5'd10, 5'd2, 5'd0, 32'h0, 32'h0, 32'hA, 32'h74, 1, 0, 0);
        bus.mem_stall = 1'b1; bus.flush = 1'b1;
        #1;
        checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL stall_id_mem: stall_id=%b, want 1", bus.stall_id); end
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.flush = 1'b0;
            checks++; if (bus.ex_rd !== 5'd9 || bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h70) begin errors++; $display("FAIL stall_hold%0d: rd=%0d v=%b pc=%h, want 9/1/70", i, bus.ex_rd, bus.ex_valid, bus.ex_pc); end
        end
        bus.mem_stall = 1'b0;
        tick();
        checks++; if (bus.ex_valid !== 1'b0 || bus.ex_rd !== 5'd0) begin errors++; $display("FAIL stall_pend_bubble: v=%b rd=%0d, want 0/0", bus.ex_valid, bus.ex_rd); end
        tick();
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd10) begin errors++; $display("FAIL stall_resume: v=%b rd=%0d, want 1/10", bus.ex_valid, bus.ex_rd); end
    endtask

    task automatic test_bypass();
        logic [31:0] exp1;
`ifdef ID_WB_BYPASS_EN
        exp1 = 32'hDEAD_BEEF;
`else
        exp1 = 32'h0;
`endif
        bus.wb_regWrite = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'hDEAD_BEEF;
        drive(1, R_TYPE, 5'd4, 5'd3, 5'd8, 32'h0, 32'h1234, 32'h0, 32'h80, 1, 0, 0);
        tick();
        checks++; if (bus.ex_rs1_data !== exp1 || bus.ex_rs2_data !== 32'h1234) begin errors++; $display("FAIL bypass_rs1: rs1=%h rs2=%h, want %h/1234", bus.ex_rs1_data, bus.ex_rs2_data, exp1); end
        bus.wb_rd = 5'd0;
        drive(1, R_TYPE, 5'd4, 5'd0, 5'd0, 32'h77, 32'h88, 32'h0, 32'h84, 1, 0, 0);
        tick();
        checks++; if (bus.ex_rs1_data !== 32'h77 || bus.ex_rs2_data !== 32'h88) begin errors++; $display("FAIL bypass_x0: rs1=%h rs2=%h, want 77/88", bus.ex_rs1_data, bus.ex_rs2_data); end
        bus.wb_regWrite = 1'b0;
    endtask

    initial begin
        bus.mem_stall = 1'b0; bus.flush = 1'b0;
        bus.wb_regWrite = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'h0;
        drive(0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        test_reset();
        test_passthrough();
        test_load_use();
        test_unused_src();
        test_flush_priority();
        test_mem_stall_flush();
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
